// File: rtl/audio_note_sequencer.sv
// Audio note sequencer: steps a programmable pattern through audio_wave (form/freq_id/new_f)
// and drives a mixer mute. Define AUDIO_SEQ_TEMPO_EN to add a tempo input scaling the beat.
module audio_note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 1562500,
  parameter int unsigned STEPS       = 16,
  localparam int unsigned AW         = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last_step,
`ifdef AUDIO_SEQ_TEMPO_EN
  input  logic [7:0]    tempo,
`endif
  output logic [1:0]    form,
  output logic [4:0]    freq_id,
  output logic          new_f,
  output logic          mute,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done
);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e        state_q, state_d;
  logic [11:0]   mem_q [STEPS];
  logic [AW-1:0] step_q, step_d, load_idx;
  logic [1:0]    form_q, form_d;
  logic [4:0]    freq_q, freq_d;
  logic          new_f_q, new_f_d, mute_q, mute_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [31:0]   presc_q, presc_d, beat_last;
  logic [3:0]    beat_q, beat_d, dur_q, dur_d;
  logic          load, at_end;
  logic [11:0]   entry;

`ifdef AUDIO_SEQ_TEMPO_EN
  logic [31:0] beat_len_q, beat_len_d;

  // Tempo is captured only when a step loads so a sounding note keeps its length.
  always_comb begin
    beat_len_d = beat_len_q;
    if (load) beat_len_d = (32'(tempo) + 32'd1) * 32'(BEAT_CYCLES);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) beat_len_q <= 32'(BEAT_CYCLES);
    else        beat_len_q <= beat_len_d;
  end

  assign beat_last = beat_len_q - 32'd1;
`else
  assign beat_last = 32'(BEAT_CYCLES) - 32'd1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < STEPS; i++) mem_q[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < STEPS)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign at_end = (step_q == last_step) || (step_q == AW'(STEPS - 1));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    form_d   = form_q;
    freq_d   = freq_q;
    new_f_d  = 1'b0;
    mute_d   = mute_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    presc_d  = presc_q;
    beat_d   = beat_q;
    dur_d    = dur_q;
    load     = 1'b0;
    load_idx = '0;
    entry    = '0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          load    = 1'b1;
          state_d = StPlay;
          busy_d  = 1'b1;
        end
      end
      StPlay: begin
        if (stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          mute_d  = 1'b1;
        end else if (presc_q == beat_last) begin
          presc_d = '0;
          if (beat_q != dur_q) begin
            beat_d = beat_q + 4'd1;
          end else if (!at_end) begin
            load     = 1'b1;
            load_idx = step_q + AW'(1);
          end else if (loop) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
            mute_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Memory read sees pre-write contents, so a same-cycle write does not affect this load.
    if (load) begin
      entry   = mem_q[load_idx];
      step_d  = load_idx;
      presc_d = '0;
      beat_d  = '0;
      dur_d   = entry[3:0];
      if (!entry[9]) begin
        form_d  = entry[11:10];
        freq_d  = entry[8:4];
        new_f_d = 1'b1;
        mute_d  = 1'b0;
      end else begin
        mute_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      form_q  <= '0;
      freq_q  <= '0;
      new_f_q <= 1'b0;
      mute_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      beat_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      form_q  <= form_d;
      freq_q  <= freq_d;
      new_f_q <= new_f_d;
      mute_q  <= mute_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      beat_q  <= beat_d;
      dur_q   <= dur_d;
    end
  end

  assign form    = form_q;
  assign freq_id = freq_q;
  assign new_f   = new_f_q;
  assign mute    = mute_q;
  assign busy    = busy_q;
  assign step    = step_q;
  assign done    = done_q;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Directed bench for audio_note_sequencer with BEAT_CYCLES=4: per-cycle vector tables per
// scenario plus hand sequences for same-cycle write/load, tempo and mid-note reset.
module tb_audio_note_sequencer;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, stop, loop;
  logic [3:0] wr_addr, last_step, step;
  logic [11:0] wr_data;
  logic [1:0] form;
  logic [4:0] freq_id;
  logic       new_f, mute, busy, done;
`ifdef AUDIO_SEQ_TEMPO_EN
  logic [7:0] tempo;
`endif

  always #5 clk = ~clk;

  audio_note_sequencer #(.BEAT_CYCLES(4), .STEPS(16)) dut (
    .clock     (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .last_step (last_step),
`ifdef AUDIO_SEQ_TEMPO_EN
    .tempo     (tempo),
`endif
    .form      (form),
    .freq_id   (freq_id),
    .new_f     (new_f),
    .mute      (mute),
    .busy      (busy),
    .step      (step),
    .done      (done)
  );

  typedef struct {
    int         scen;
    int         t;
    logic       is_chk;
    logic       start, stop;
    logic       new_f, mute, busy, done;
    logic [1:0] form;
    logic [4:0] freq;
    logic [3:0] step;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add_in(int s, int t, logic st, logic sp);
    vec_t v = '{s, t, 1'b0, st, sp, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 4'd0};
    vecs.push_back(v);
  endfunction

  function automatic void add_chk(int s, int t, logic nf, logic mu, logic bu, logic dn,
                                  logic [1:0] fo, logic [4:0] fr, logic [3:0] st);
    vec_t v = '{s, t, 1'b1, 1'b0, 1'b0, nf, mu, bu, dn, fo, fr, st};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic nf, input logic mu, input logic bu,
                           input logic dn, input logic [1:0] fo, input logic [4:0] fr,
                           input logic [3:0] st);
    check({tag, "_new_f"},   32'(new_f),   32'(nf));
    check({tag, "_mute"},    32'(mute),    32'(mu));
    check({tag, "_busy"},    32'(busy),    32'(bu));
    check({tag, "_done"},    32'(done),    32'(dn));
    check({tag, "_form"},    32'(form),    32'(fo));
    check({tag, "_freq_id"}, 32'(freq_id), 32'(fr));
    check({tag, "_step"},    32'(step),    32'(st));
  endtask

  // Entered at a falling edge; iteration t samples cycle Tt then drives that cycle's inputs.
  task automatic run_scen(input int s, input int max_t);
    for (int t = 0; t <= max_t; t++) begin
      start = 1'b0;
      stop  = 1'b0;
      foreach (vecs[i]) begin
        if (vecs[i].scen == s && vecs[i].t == t) begin
          if (vecs[i].is_chk)
            check_all($sformatf("s%0d_t%0d", s, t), vecs[i].new_f, vecs[i].mute, vecs[i].busy,
                      vecs[i].done, vecs[i].form, vecs[i].freq, vecs[i].step);
          else begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_step = 4'd1;
`ifdef AUDIO_SEQ_TEMPO_EN
    tempo = 8'd0;
`endif

    // s1: two steps, no loop; start while busy at T4 is ignored
    add_in (1, 0, 1'b1, 1'b0);
    add_in (1, 4, 1'b1, 1'b0);
    add_chk(1, 1,  1, 0, 1, 0, 2'd0, 5'd12, 4'd0);
    add_chk(1, 2,  0, 0, 1, 0, 2'd0, 5'd12, 4'd0);
    add_chk(1, 5,  0, 0, 1, 0, 2'd0, 5'd12, 4'd0);
    add_chk(1, 8,  0, 0, 1, 0, 2'd0, 5'd12, 4'd0);
    add_chk(1, 9,  1, 0, 1, 0, 2'd2, 5'd5,  4'd1);
    add_chk(1, 12, 0, 0, 1, 0, 2'd2, 5'd5,  4'd1);
    add_chk(1, 13, 0, 1, 0, 1, 2'd2, 5'd5,  4'd1);
    add_chk(1, 14, 0, 1, 0, 0, 2'd2, 5'd5,  4'd1);
    // s2: loop wraps to step 0, then stop
    add_in (2, 0, 1'b1, 1'b0);
    add_in (2, 14, 1'b0, 1'b1);
    add_chk(2, 9,  1, 0, 1, 0, 2'd2, 5'd5,  4'd1);
    add_chk(2, 13, 1, 0, 1, 0, 2'd0, 5'd12, 4'd0);
    add_chk(2, 15, 0, 1, 0, 0, 2'd0, 5'd12, 4'd0);
    // s3: stop at T5
    add_in (3, 0, 1'b1, 1'b0);
    add_in (3, 5, 1'b0, 1'b1);
    add_chk(3, 5,  0, 0, 1, 0, 2'd0, 5'd12, 4'd0);
    add_chk(3, 6,  0, 1, 0, 0, 2'd0, 5'd12, 4'd0);
    add_chk(3, 9,  0, 1, 0, 0, 2'd0, 5'd12, 4'd0);
    add_chk(3, 13, 0, 1, 0, 0, 2'd0, 5'd12, 4'd0);
    // s4: start and stop together while idle
    add_in (4, 0, 1'b1, 1'b1);
    add_chk(4, 1,  0, 1, 0, 0, 2'd0, 5'd12, 4'd0);
    add_chk(4, 2,  0, 1, 0, 0, 2'd0, 5'd12, 4'd0);
    // s5: entry1 is a rest
    add_in (5, 0, 1'b1, 1'b0);
    add_chk(5, 1,  1, 0, 1, 0, 2'd0, 5'd12, 4'd0);
    add_chk(5, 9,  0, 1, 1, 0, 2'd0, 5'd12, 4'd1);
    add_chk(5, 13, 0, 1, 0, 1, 2'd0, 5'd12, 4'd1);
`ifdef AUDIO_SEQ_TEMPO_EN
    // s6: tempo=1 doubles the beat
    add_in (6, 0, 1'b1, 1'b0);
    add_chk(6, 1,  1, 0, 1, 0, 2'd1, 5'd3, 4'd0);
    add_chk(6, 8,  0, 0, 1, 0, 2'd1, 5'd3, 4'd0);
    add_chk(6, 9,  0, 1, 0, 1, 2'd1, 5'd3, 4'd0);
`endif

    repeat (3) @(negedge clk);
    check_all("rst_hold", 0, 1, 0, 0, 2'd0, 5'd0, 4'd0);
    reset = 1'b1;
    @(negedge clk);
    check_all("rst_rel", 0, 1, 0, 0, 2'd0, 5'd0, 4'd0);

    wr(4'd0, 12'h0C1);
    wr(4'd1, 12'h850);
    last_step = 4'd1;
    loop = 1'b0;
    run_scen(1, 15);
    loop = 1'b1;
    run_scen(2, 16);
    loop = 1'b0;
    run_scen(3, 14);
    run_scen(4, 2);
    wr(4'd1, 12'hA50);
    run_scen(5, 14);

    // Write entry1 in the same cycle it loads: old data plays, new data plays next pass
    wr(4'd1, 12'h850);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    wr(4'd1, 12'h8A0);
    check_all("wrld_t9", 1, 0, 1, 0, 2'd2, 5'd5, 4'd1);
    repeat (4) @(negedge clk);
    check_all("wrld_t13", 0, 1, 0, 1, 2'd2, 5'd5, 4'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_all("wrld2_t9", 1, 0, 1, 0, 2'd2, 5'd10, 4'd1);
    repeat (5) @(negedge clk);

`ifdef AUDIO_SEQ_TEMPO_EN
    last_step = 4'd0;
    tempo = 8'd1;
    wr(4'd0, 12'h430);
    run_scen(6, 10);
    tempo = 8'd0;
`endif

    // Reset mid-note clears state and pattern memory
    last_step = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("midrst", 0, 1, 0, 0, 2'd0, 5'd0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    last_step = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("post_rst_t1", 1, 0, 1, 0, 2'd0, 5'd0, 4'd0);
    repeat (4) @(negedge clk);
    check_all("post_rst_t5", 0, 1, 0, 1, 2'd0, 5'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
